// File: rtl/lc3_decode_pkg.sv
// lc3_decode_pkg: opcodes, control encodings, history entry and decode helpers for lc3_decode_issue
package lc3_decode_pkg;

    typedef enum logic [3:0] {
        OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
        OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
        OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011,
        OP_JMP = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {W_ALU = 2'd0, W_MEM = 2'd1, W_PC = 2'd2} wctl_e;

    localparam logic [1:0] PC1_OFF11 = 2'b00;
    localparam logic [1:0] PC1_OFF9  = 2'b01;
    localparam logic [1:0] PC1_OFF6  = 2'b10;
    localparam logic [1:0] PC1_ZERO  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;
    // Address-generating ops (loads, stores, LEA) present the 01 encoding on alu_control
    localparam logic [1:0] ALU_ADDR = 2'b01;

    typedef struct packed {
        logic [2:0] dr;
        logic       alu_w;
        logic       ld_w;
    } hist_t;

    typedef struct packed {
        logic [5:0] e;
        wctl_e      w;
        logic       m;
        logic       valid;
    } dec_t;

    // Control decode: E_Control = {alu, pcsel1, pcsel2, op2sel}
    function automatic dec_t decode(input logic [15:0] ir);
        dec_t d;
        d = '0;
        d.valid = 1'b1;
        case (opcode_e'(ir[15:12]))
            OP_ADD:  d.e = {ALU_ADD, PC1_OFF11, 1'b0, ~ir[5]};
            OP_AND:  d.e = {ALU_AND, PC1_OFF11, 1'b0, ~ir[5]};
            OP_NOT:  d.e = {ALU_NOT, PC1_OFF11, 2'b00};
            OP_BR:   d.e = {ALU_ADD, PC1_OFF9, 2'b10};
            OP_JMP:  d.e = {ALU_ADD, PC1_ZERO, 2'b00};
            OP_LD:   begin d.e = {ALU_ADDR, PC1_OFF9, 2'b10}; d.w = W_MEM; end
            OP_LDR:  begin d.e = {ALU_ADDR, PC1_OFF6, 2'b00}; d.w = W_MEM; end
            OP_LDI:  begin d.e = {ALU_ADDR, PC1_OFF9, 2'b10}; d.w = W_MEM; d.m = 1'b1; end
            OP_LEA:  begin d.e = {ALU_ADDR, PC1_OFF9, 2'b10}; d.w = W_PC; end
            OP_ST:   d.e = {ALU_ADDR, PC1_OFF9, 2'b10};
            OP_STR:  d.e = {ALU_ADDR, PC1_OFF6, 2'b00};
            OP_STI:  begin d.e = {ALU_ADDR, PC1_OFF9, 2'b10}; d.m = 1'b1; end
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Operand usage and writer class: {use_sr1, use_sr2, alu_writer, load_writer}
    function automatic logic [3:0] hazard_info(input opcode_e op, input logic imm);
        logic alu_fmt;
        alu_fmt = op inside {OP_ADD, OP_AND};
        return {op inside {OP_ADD, OP_AND, OP_NOT, OP_JMP, OP_LDR, OP_STR},
                (alu_fmt && !imm) || (op inside {OP_ST, OP_STR, OP_STI}),
                op inside {OP_ADD, OP_AND, OP_NOT, OP_LEA},
                op inside {OP_LD, OP_LDR, OP_LDI}};
    endfunction

endpackage

// File: rtl/lc3_decode_issue_hazard.sv
// lc3_hazard_tracker: two-deep issue history and operand bypass compare
module lc3_hazard_tracker import lc3_decode_pkg::*; (
    input  logic       clock,
    input  logic       reset,
    input  logic       issue_i,
    input  logic       flush_i,
    input  logic [3:0] op_i,
    input  logic       imm_i,
    input  logic [2:0] dr_i,
    input  logic [2:0] sr1_i,
    input  logic [2:0] sr2_i,
    output logic [3:0] byp_o
);

    logic  use1, use2, alu_w, ld_w, ba1, ba2;
    hist_t age1_q;
    logic [2:0] age2_dr_q;
    logic  age2_ld_q;

    assign {use1, use2, alu_w, ld_w} = hazard_info(opcode_e'(op_i), imm_i);

    // Shift the history on every issue; a flush forgets everything in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset || flush_i) begin
            age1_q    <= '0;
            age2_dr_q <= '0;
            age2_ld_q <= 1'b0;
        end else if (issue_i) begin
            age1_q    <= '{dr: dr_i, alu_w: alu_w, ld_w: ld_w};
            age2_dr_q <= age1_q.dr;
            age2_ld_q <= age1_q.ld_w;
        end
    end

    // ALU result one issue back wins over a load two issues back
    always_comb begin
        ba1   = use1 && age1_q.alu_w && age1_q.dr == sr1_i;
        ba2   = use2 && age1_q.alu_w && age1_q.dr == sr2_i;
        byp_o = {ba1, ba2,
                 use1 && age2_ld_q && age2_dr_q == sr1_i && !ba1,
                 use2 && age2_ld_q && age2_dr_q == sr2_i && !ba2};
    end

endmodule

// File: rtl/lc3_decode_issue.sv
// lc3_decode_issue: LC3 decode/issue stage driving execute_in; bypass enabled by LC3_DECODE_BYPASS_EN
module lc3_decode_issue import lc3_decode_pkg::*; (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic        flush,
    input  logic [15:0] instr_dout,
    input  logic [15:0] npc_in,
    input  logic [15:0] rf_vsr1,
    input  logic [15:0] rf_vsr2,
    input  logic [15:0] mem_data_in,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control_out,
    output logic        Mem_Control_out,
    output logic [15:0] VSR1,
    output logic [15:0] VSR2,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic        enable_execute,
    output logic [15:0] Mem_Bypass_Val
);

    dec_t dec;
    logic issue, store;
    logic [15:0] ir_q, npc_q, vsr1_q, vsr2_q, mbv_q;
    logic [5:0]  e_q;
    wctl_e       w_q;
    logic        m_q, en_q;
    logic [3:0]  byp_d, byp_q;

    assign dec   = decode(instr_dout);
    assign issue = enable_decode && !flush;
    assign store = instr_dout[15:12] inside {OP_ST, OP_STR, OP_STI};
    assign sr1   = instr_dout[8:6];
    assign sr2   = store ? instr_dout[11:9] : instr_dout[2:0];

`ifdef LC3_DECODE_BYPASS_EN
    lc3_hazard_tracker u_hazard (
        .clock   (clock),
        .reset   (reset),
        .issue_i (issue),
        .flush_i (flush),
        .op_i    (instr_dout[15:12]),
        .imm_i   (instr_dout[5]),
        .dr_i    (instr_dout[11:9]),
        .sr1_i   (sr1),
        .sr2_i   (sr2),
        .byp_o   (byp_d)
    );
`else
    assign byp_d = 4'b0;
`endif

    // Instruction, controls and operands load on issue and hold otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_q   <= '0;
            npc_q  <= '0;
            vsr1_q <= '0;
            vsr2_q <= '0;
            e_q    <= '0;
            w_q    <= W_ALU;
            m_q    <= 1'b0;
        end else if (issue) begin
            ir_q   <= instr_dout;
            npc_q  <= npc_in;
            vsr1_q <= rf_vsr1;
            vsr2_q <= rf_vsr2;
            e_q    <= dec.e;
            w_q    <= dec.w;
            m_q    <= dec.m;
        end
    end

    // Issue valid is one-shot; bypass selects hold on stall and clear on flush
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_q  <= 1'b0;
            byp_q <= '0;
        end else begin
            en_q  <= issue && dec.valid;
            byp_q <= issue ? byp_d : flush ? 4'b0 : byp_q;
        end
    end

    // Memory-stage data is re-timed every cycle regardless of issue
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mbv_q <= '0;
        else        mbv_q <= mem_data_in;
    end

    assign IR              = ir_q;
    assign npc_out         = npc_q;
    assign VSR1            = vsr1_q;
    assign VSR2            = vsr2_q;
    assign E_Control       = e_q;
    assign W_Control_out   = w_q;
    assign Mem_Control_out = m_q;
    assign enable_execute  = en_q;
    assign Mem_Bypass_Val  = mbv_q;
    assign {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = byp_q;

endmodule

// File: tb/tb_lc3_decode_issue.sv
// tb_lc3_decode_issue: scoreboard bench with a table-driven reference model of the decode/issue stage
module tb_lc3_decode_issue;

    logic        clock, reset, enable_decode, flush;
    logic [15:0] instr_dout, npc_in, rf_vsr1, rf_vsr2, mem_data_in;
    logic [2:0]  sr1, sr2;
    logic [15:0] IR, npc_out, VSR1, VSR2, Mem_Bypass_Val;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, enable_execute;

    lc3_decode_issue dut (
        .clock(clock), .reset(reset), .enable_decode(enable_decode), .flush(flush),
        .instr_dout(instr_dout), .npc_in(npc_in), .rf_vsr1(rf_vsr1), .rf_vsr2(rf_vsr2),
        .mem_data_in(mem_data_in), .sr1(sr1), .sr2(sr2), .IR(IR), .npc_out(npc_out),
        .E_Control(E_Control), .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
        .VSR1(VSR1), .VSR2(VSR2), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
        .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
        .enable_execute(enable_execute), .Mem_Bypass_Val(Mem_Bypass_Val)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] ir, npc, vsr1, vsr2, mbv;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m, en, ba1, ba2, bm1, bm2;
    } exp_t;

    typedef struct {
        logic [2:0] dr;
        bit         alu;
        bit         ld;
    } h_t;

    // E_Control per opcode; ADD/AND op2select is added from instr[5]
    logic [5:0] e_tab [16] = '{6'b000110, 6'b000000, 6'b010110, 6'b010110,
                               6'b000000, 6'b010000, 6'b011000, 6'b011000,
                               6'b000000, 6'b100000, 6'b010110, 6'b010110,
                               6'b001100, 6'b000000, 6'b010110, 6'b000000};

    exp_t exp_q[$];
    exp_t m = '0;
    h_t   hist[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(string name, logic [15:0] act, logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endfunction

    function automatic logic [2:0] ref_sr2(logic [15:0] ins);
        int op = int'(ins[15:12]);
        return (op == 3 || op == 7 || op == 11) ? ins[11:9] : ins[2:0];
    endfunction

    // Reference: what the execute_in bundle must look like after this edge
    function automatic void model_step();
        int op = int'(instr_dout[15:12]);
        bit alu_fmt = (op == 1 || op == 5);
        bit rd1 = op inside {1, 5, 9, 12, 6, 7};
        bit rd2 = (alu_fmt && !instr_dout[5]) || op inside {3, 7, 11};
        logic [2:0] s1 = instr_dout[8:6];
        logic [2:0] s2 = ref_sr2(instr_dout);
        bit a1 = 0, a2 = 0, b1 = 0, b2 = 0;
        if (!reset) begin
            m = '0;
            hist.delete();
            return;
        end
        m.mbv = mem_data_in;
        if (flush) begin
            m.en = 0;
            {m.ba1, m.ba2, m.bm1, m.bm2} = 4'b0;
            hist.delete();
        end else if (enable_decode) begin
            m.ir   = instr_dout;
            m.npc  = npc_in;
            m.vsr1 = rf_vsr1;
            m.vsr2 = rf_vsr2;
            m.e    = e_tab[op] | {5'b0, alu_fmt && !instr_dout[5]};
            m.w    = (op == 2 || op == 6 || op == 10) ? 2'd1 : (op == 14) ? 2'd2 : 2'd0;
            m.m    = (op == 10 || op == 11);
            m.en   = !(op inside {4, 8, 13, 15});
`ifdef LC3_DECODE_BYPASS_EN
            if (hist.size() > 0 && hist[0].alu) begin
                a1 = rd1 && hist[0].dr == s1;
                a2 = rd2 && hist[0].dr == s2;
            end
            if (hist.size() > 1 && hist[1].ld) begin
                b1 = rd1 && hist[1].dr == s1 && !a1;
                b2 = rd2 && hist[1].dr == s2 && !a2;
            end
`endif
            {m.ba1, m.ba2, m.bm1, m.bm2} = {a1, a2, b1, b2};
            hist.push_front('{dr: instr_dout[11:9], alu: op inside {1, 5, 9, 14}, ld: op inside {2, 6, 10}});
            if (hist.size() > 2) void'(hist.pop_back());
        end else begin
            m.en = 0;
        end
    endfunction

    task automatic cyc(bit rst, bit en, bit fl, logic [15:0] ins);
        @(negedge clock);
        #1;
        reset         = rst;
        enable_decode = en;
        flush         = fl;
        instr_dout    = ins;
        npc_in        = 16'($urandom);
        rf_vsr1       = 16'($urandom);
        rf_vsr2       = 16'($urandom);
        mem_data_in   = 16'($urandom);
        #1;
        chk("sr1", {13'b0, sr1}, {13'b0, ins[8:6]});
        chk("sr2", {13'b0, sr2}, {13'b0, ref_sr2(ins)});
        if (!rst) begin
            chk("async_rst_IR", IR, 16'h0);
            chk("async_rst_en", {15'b0, enable_execute}, 16'h0);
        end
        @(posedge clock);
        model_step();
        exp_q.push_back(m);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] ins = 16'($urandom);
        ins[11:9] = 3'($urandom_range(0, 3));
        ins[8:6]  = 3'($urandom_range(0, 3));
        ins[2:0]  = 3'($urandom_range(0, 3));
        return ins;
    endfunction

    // Monitor: every falling edge the DUT presents one registered bundle
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin : mon
            exp_t x;
            x = exp_q.pop_front();
            chk("IR", IR, x.ir);
            chk("npc_out", npc_out, x.npc);
            chk("E_Control", {10'b0, E_Control}, {10'b0, x.e});
            chk("W_Control", {14'b0, W_Control_out}, {14'b0, x.w});
            chk("Mem_Control", {15'b0, Mem_Control_out}, {15'b0, x.m});
            chk("VSR1", VSR1, x.vsr1);
            chk("VSR2", VSR2, x.vsr2);
            chk("enable_execute", {15'b0, enable_execute}, {15'b0, x.en});
            chk("bypass", {12'b0, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2},
                {12'b0, x.ba1, x.ba2, x.bm1, x.bm2});
            chk("Mem_Bypass_Val", Mem_Bypass_Val, x.mbv);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; enable_decode = 1'b0; flush = 1'b0;
        instr_dout = '0; npc_in = '0; rf_vsr1 = '0; rf_vsr2 = '0; mem_data_in = '0;
        for (int i = 0; i < 3; i++) cyc(0, 1'($urandom), 1'($urandom), 16'($urandom));
        cyc(1, 1, 0, 16'h1283);
        cyc(1, 1, 0, 16'h1441);
        cyc(1, 1, 0, 16'h2605);
        cyc(1, 1, 0, 16'h903F);
        cyc(1, 1, 0, 16'h18E1);
        cyc(1, 1, 0, 16'h1283);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, rand_instr());
        cyc(1, 1, 1, 16'h1283);
        cyc(1, 1, 0, 16'h1441);
        cyc(1, 1, 0, 16'hA205);
        cyc(1, 1, 0, 16'hE205);
        cyc(1, 1, 0, 16'hF025);
        cyc(1, 1, 0, 16'h1283);
        cyc(0, 1, 0, 16'h1441);
        cyc(1, 1, 0, 16'h1441);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 19) == 0, rand_instr());
        @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_decode_issue.md
# lc3_decode_issue

Decode/issue stage that produces the complete execute_in bundle consumed by the LC3 execute stage. It registers the fetched instruction and NPC, decodes E_Control, W_Control and Mem_Control, captures register-file operands, and generates the four bypass selects from a two-deep issue history. It sits between fetch/register file and execute, and is the driving end of the execute_in bus.

## Interface
Parameters:
- none; widths are fixed by the LC3 ISA.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- enable_decode  in  1  issue qualifier from the controller
- flush  in  1  squash the next issue; clear history
- instr_dout  in  16  fetched instruction
- npc_in  in  16  PC+1 of instr_dout
- rf_vsr1, rf_vsr2  in  16  register-file read data for sr1/sr2
- mem_data_in  in  16  memory-stage load data
- sr1, sr2  out  3  register-file read addresses; combinational from instr_dout
- IR, npc_out  out  16  registered instruction / NPC
- E_Control  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- W_Control_out  out  2  0 ALU, 1 memory, 2 PC (LEA)
- Mem_Control_out  out  1  1 = indirect (LDI/STI)
- VSR1, VSR2  out  16  registered operands
- bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2  out  1  operand bypass selects
- enable_execute  out  1  issue valid to execute
- Mem_Bypass_Val  out  16  registered mem_data_in

## Operation
- sr1 = instr[8:6]. sr2 = instr[11:9] for ST/STR/STI, otherwise instr[2:0].
- Decode (alu, pcsel1, pcsel2, op2sel / W / Mem):
  - ADD 0001: 00,00,0,instr[5]==0 / 0 / 0
  - AND 0101: 01, same otherwise
  - NOT 1001: 10,00,0,0 / 0 / 0
  - BR 0000: 00,01,1,0 / 0 / 0
  - JMP 1100: 00,11,0,0 / 0 / 0
  - LD 0010: 01/1; LDR 0110: 10/0; LDI 1010: 01/1; LEA 1110: 01/1; ST 0011: 01/1; STR 0111: 10/0; STI 1011: 01/1 (pcsel1/pcsel2)
  - W_Control: LD/LDR/LDI = 1, LEA = 2, else 0. Mem_Control = 1 only for LDI/STI.
- Unsupported opcodes (0100, 1000, 1101, 1111): E_Control=0, W=0, Mem=0, enable_execute=0. Recorded in history as a non-writer.
- History: age1 = last issued {DR=IR[11:9], alu_writer}; age2 = issue before that {DR, load_writer}. alu_writer covers ADD/AND/NOT/LEA. load_writer covers LD/LDR/LDI.
- bypass_alu_n = age1.alu_writer && age1.DR == srn.
- bypass_mem_n = age2.load_writer && age2.DR == srn && !bypass_alu_n (ALU bypass has priority).
- Bypass is evaluated only for operands the opcode actually reads. Otherwise it is 0.

## Timing
- Reset (async, reset==0): every output register is 0, and history is cleared (writer flags 0).
- Latency is 1 cycle. On a rising edge with enable_decode=1 and flush=0, IR, npc_out, controls, VSR1/VSR2 and bypass* load from the current inputs, enable_execute←1 (0 for unsupported opcodes), and history shifts.
- enable_decode=0: all outputs hold, enable_execute←0, and history holds.
- flush=1 (overrides enable_decode): enable_execute←0, bypass*←0, history cleared, other outputs hold.
- Mem_Bypass_Val loads mem_data_in on every edge, unconditionally.
- Reset released mid-stream: the first issue sees empty history, so no bypass.

## Configuration
- LC3_DECODE_BYPASS_EN defined: history and bypass logic are compiled in as above.
- Not defined: bypass_* are tied 0, the history registers are omitted, and Mem_Bypass_Val is still registered.

## Structure
- Package lc3_decode_pkg holds:
  - opcode enum
  - W_Control enum (W_ALU, W_MEM, W_PC)
  - pcselect1 constants (PC1_OFF11, PC1_OFF9, PC1_OFF6, PC1_ZERO)
  - alu_control constants
  - history-entry struct
- One sub-module, lc3_hazard_tracker, owns the history and bypass compare. It is instantiated only under LC3_DECODE_BYPASS_EN.

## Test plan
- Reset: hold reset=0 with random inputs -> all outputs 0. Release, then issue ADD 0x1283 -> next cycle IR=0x1283, E_Control=6'b000001, W=0, enable_execute=1.
- ALU bypass: ADD R1 (0x1283) then ADD R2,R1,R1 (0x1441) -> second issue has bypass_alu_1=1, bypass_alu_2=1, bypass_mem_*=0.
- Mem bypass: LD R3 (0x2605), NOT R0 (0x903F), ADD R4,R3,#1 (0x18E1) -> third issue has bypass_mem_1=1, bypass_alu_1=0. Mem_Bypass_Val tracks mem_data_in one cycle late.
- Stall and flush: enable_decode=0 for 3 cycles -> outputs hold, enable_execute=0. Then flush=1 -> the following ADD R1,R1 sees no bypass.
- Indirect/LEA: LDI 0xA205 -> W=1, Mem=1, E_Control=6'b010110. LEA 0xE205 -> W=2, Mem=0.
- Unsupported opcode 0xF025 -> enable_execute=0, E_Control=0. With the macro undefined, the ALU-bypass sequence yields bypass_alu_*=0.
